fpu_norm_round: RTL and testbench

Normalize/round/pack stage directly downstream of the FPU add and multiply datapaths. It takes an unnormalized signed significand with a wide biased exponent and produces an IEEE-754 binary32 result plus exception flags. The block is a 2-stage pipeline with valid/ready handshake on both sides, running at full throughput. Subnormal results are flushed to zero.

---
 rtl/fpu_norm_round.sv | 227 ++++++++++++++++++++++
 tb/tb_fpu_norm_round.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_norm_round.sv
// fpu_norm_round: normalize / round / pack stage behind the FPU add and mul
// datapaths. Two registered stages (normalize, then round+pack) with a
// valid/ready handshake on both sides. Subnormal results flush to zero.
module fpu_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W+1:0]      in_exp,
    input  logic [FRAC_W+3:0]     in_mant,
    input  logic                  in_sticky,
    input  logic [1:0]            in_class,
    input  logic                  in_invalid,
    input  logic [2:0]            in_rm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] out_result,
    output logic [3:0]            out_flags
);

    // Input significand width, and width after normalization (leading 1 at top)
    localparam int MW  = FRAC_W + 4;
    localparam int NW  = FRAC_W + 3;
    // One extra exponent bit over the input so +1 / -lz can never wrap
    localparam int EW  = EXP_W + 3;
    localparam int LZW = $clog2(NW + 1);
    localparam int RW  = 1 + EXP_W + FRAC_W;

    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);

    localparam logic [1:0] CLS_NORM = 2'b00;
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // Flag vectors, ordered {NV, OF, UF, NX}
    localparam logic [3:0] FL_OVF = 4'b0101;
    localparam logic [3:0] FL_UNF = 4'b0011;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = ~out_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: normalize
    // ------------------------------------------------------------------
    logic [LZW-1:0]       lz;
    logic                 lz_found;
    logic signed [EW-1:0] exp_ext;

    logic                 s1_sign_d,   s1_sign_q;
    logic signed [EW-1:0] s1_exp_d,    s1_exp_q;
    logic [NW-1:0]        s1_mant_d,   s1_mant_q;
    logic                 s1_sticky_d, s1_sticky_q;
    logic [1:0]           s1_cls_d,    s1_cls_q;
    logic                 s1_inv_d,    s1_inv_q;
    logic [2:0]           s1_rm_d,     s1_rm_q;

    assign exp_ext = {in_exp[EXP_W+1], in_exp};

    // Leading-zero count over the bits below the carry bit
    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = NW - 1; i >= 0; i--) begin
            if (!lz_found && in_mant[i]) begin
                lz       = LZW'(NW - 1 - i);
                lz_found = 1'b1;
            end
        end
    end

    // Normalize: carry bit set -> shift right one, else shift out leading zeros
    always_comb begin
        s1_sign_d = in_sign;
        s1_inv_d  = in_invalid;
        s1_rm_d   = in_rm;
        s1_cls_d  = in_class;
        if (in_class == CLS_NORM && in_mant == '0) begin
            s1_cls_d = CLS_ZERO;
        end
        if (in_mant[MW-1]) begin
            s1_mant_d   = in_mant[MW-1:1];
            s1_sticky_d = in_sticky | in_mant[0];
            s1_exp_d    = exp_ext + EW'(1);
        end else begin
            s1_mant_d   = in_mant[NW-1:0] << lz;
            s1_sticky_d = in_sticky;
            s1_exp_d    = exp_ext - EW'(lz);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round and pack
    // ------------------------------------------------------------------
    logic                 g_bit, r_bit, lsb_bit, inexact, inc;
    logic [FRAC_W+1:0]    sig_sum;
    logic                 carry;
    logic signed [EW-1:0] exp_rnd;
    logic                 ovf_to_inf;
    logic [RW-1:0]        out_result_d, out_result_q;
    logic [3:0]           out_flags_d,  out_flags_q;

    // Increment decision, rounded significand and overflow/underflow packing
    always_comb begin
        g_bit   = s1_mant_q[1];
        r_bit   = s1_mant_q[0];
        lsb_bit = s1_mant_q[2];
        inexact = g_bit | r_bit | s1_sticky_q;

        case (s1_rm_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s1_sign_q & inexact;
            RM_RUP:  inc = ~s1_sign_q & inexact;
            RM_RMM:  inc = g_bit;
            default: inc = g_bit & (r_bit | s1_sticky_q | lsb_bit);
        endcase

        sig_sum = {1'b0, s1_mant_q[NW-1:2]} + {{(FRAC_W+1){1'b0}}, inc};
        carry   = sig_sum[FRAC_W+1];
        exp_rnd = s1_exp_q + {{(EW-1){1'b0}}, carry};

        // Directed-rounding modes saturate to max finite on the side they round away from
        case (s1_rm_q)
            RM_RTZ:  ovf_to_inf = 1'b0;
            RM_RDN:  ovf_to_inf = s1_sign_q;
            RM_RUP:  ovf_to_inf = ~s1_sign_q;
            default: ovf_to_inf = 1'b1;
        endcase

        out_result_d = '0;
        out_flags_d  = '0;
        case (s1_cls_q)
            CLS_ZERO: begin
                out_result_d = {s1_sign_q, {(RW-1){1'b0}}};
            end
            CLS_INF: begin
                out_result_d = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            end
            CLS_NAN: begin
                out_result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
                out_flags_d  = {s1_inv_q, 3'b000};
            end
            default: begin
                if (s1_exp_q <= EXP_ZERO) begin
                    // Subnormal or smaller: flush to signed zero
                    out_result_d = {s1_sign_q, {(RW-1){1'b0}}};
                    out_flags_d  = FL_UNF;
                end else if (exp_rnd >= EXP_MAX) begin
                    out_flags_d = FL_OVF;
                    if (ovf_to_inf) begin
                        out_result_d = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    end else begin
                        out_result_d = {s1_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
                    end
                end else begin
                    out_result_d = {s1_sign_q, exp_rnd[EXP_W-1:0],
                                    carry ? {FRAC_W{1'b0}} : sig_sum[FRAC_W-1:0]};
                    out_flags_d  = {3'b000, inexact};
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    // Stage 1 loads when it can hand off; output stage holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_mant_q    <= '0;
            s1_sticky_q  <= 1'b0;
            s1_cls_q     <= '0;
            s1_inv_q     <= 1'b0;
            s1_rm_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q   <= s1_sign_d;
                    s1_exp_q    <= s1_exp_d;
                    s1_mant_q   <= s1_mant_d;
                    s1_sticky_q <= s1_sticky_d;
                    s1_cls_q    <= s1_cls_d;
                    s1_inv_q    <= s1_inv_d;
                    s1_rm_q     <= s1_rm_d;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_result_q <= out_result_d;
                    out_flags_q  <= out_flags_d;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb_fpu_norm_round: directed plus random stimulus against an arithmetic
// reference model; a negedge monitor scoreboards every output transfer.
module tb_fpu_norm_round;

    typedef struct packed {
        logic        sign;
        logic [9:0]  ex;
        logic [26:0] mant;
        logic        sticky;
        logic [1:0]  cls;
        logic        inv;
        logic [2:0]  rm;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_sticky;
    logic [1:0]  in_class;
    logic        in_invalid;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    op_t         cur;
    logic [35:0] exp_q[$];
    logic        hold_pend = 1'b0;
    logic [35:0] hold_val  = '0;
    int          n_chk  = 0;
    int          n_fail = 0;

    assign in_sign    = cur.sign;
    assign in_exp     = cur.ex;
    assign in_mant    = cur.mant;
    assign in_sticky  = cur.sticky;
    assign in_class   = cur.cls;
    assign in_invalid = cur.inv;
    assign in_rm      = cur.rm;

    always #5 clk = ~clk;

    fpu_norm_round #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_sticky(in_sticky), .in_class(in_class), .in_invalid(in_invalid),
        .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    task automatic chk(input string tag, input logic [35:0] act, input logic [35:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, act, exp_v);
        end
    endtask

    // Reference: value = mant * 2^(exp-127-25); normalize by arithmetic,
    // round the 24-bit significand as an integer, then pack. Returns {flags,result}.
    function automatic logic [35:0] ref_model(input op_t op);
        longint m;
        int     e, q, rem;
        bit     s, g, r, nx, inc, to_inf;
        if (op.cls == 2'b11) return {op.inv, 3'b000, 32'h7FC00000};
        if (op.cls == 2'b10) return {4'b0000, op.sign, 8'hFF, 23'd0};
        m = longint'(op.mant);
        if (op.cls == 2'b01 || m == 0) return {4'b0000, op.sign, 31'd0};
        e = $signed(op.ex);
        s = op.sticky;
        while (m >= (64'sd1 << 26)) begin
            if (m % 2 != 0) s = 1'b1;
            m = m / 2;
            e = e + 1;
        end
        while (m < (64'sd1 << 25)) begin
            m = m * 2;
            e = e - 1;
        end
        if (e <= 0) return {4'b0011, op.sign, 31'd0};
        q   = int'(m / 4);
        rem = int'(m % 4);
        g   = (rem >= 2);
        r   = (rem % 2) != 0;
        nx  = (rem != 0) || s;
        case (op.rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = op.sign && nx;
            3'd3:    inc = !op.sign && nx;
            3'd4:    inc = g;
            default: inc = (g && (r || s)) || (g && !r && !s && (q % 2 == 1));
        endcase
        q = q + int'(inc);
        if (q == (1 << 24)) begin
            q = 1 << 23;
            e = e + 1;
        end
        if (e >= 255) begin
            case (op.rm)
                3'd1:    to_inf = 1'b0;
                3'd2:    to_inf = op.sign;
                3'd3:    to_inf = !op.sign;
                default: to_inf = 1'b1;
            endcase
            if (to_inf) return {4'b0101, op.sign, 8'hFF, 23'd0};
            return {4'b0101, op.sign, 31'h7F7FFFFF};
        end
        return {3'b000, nx, op.sign, 8'(e), 23'(q)};
    endfunction

    function automatic op_t mk(input logic sgn, input int e, input logic [26:0] m,
                               input logic [1:0] c, input logic iv, input logic [2:0] rm);
        op_t o;
        o.sign = sgn; o.ex = 10'(e); o.mant = m; o.sticky = 1'b0;
        o.cls = c; o.inv = iv; o.rm = rm;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  e;
        case ($urandom_range(0, 3))
            0:       e = int'($urandom_range(100, 150));
            1:       e = int'($urandom_range(0, 60)) - 30;
            2:       e = int'($urandom_range(240, 270));
            default: e = int'($urandom_range(0, 1023));
        endcase
        o.ex     = 10'(e);
        o.sign   = 1'($urandom);
        o.mant   = 27'($urandom) >> $urandom_range(0, 27);
        o.sticky = 1'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            o.mant[1:0] = 2'b10;
            o.sticky    = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) o.mant = 27'h3FFFFFC | 27'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            7:       o.cls = 2'b01;
            8:       o.cls = 2'b10;
            9:       o.cls = 2'b11;
            default: o.cls = 2'b00;
        endcase
        o.inv = 1'($urandom);
        o.rm  = 3'($urandom_range(0, 7));
        return o;
    endfunction

    // Scoreboard: record accepted ops, check each output transfer in order,
    // and check the output is held while stalled.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) chk("hold", {out_flags, out_result}, hold_val);
            hold_pend <= out_valid && !out_ready;
            hold_val  <= {out_flags, out_result};
            if (out_valid && out_ready) begin
                chk("q_nonempty", 36'(exp_q.size() != 0), 36'd1);
                if (exp_q.size() != 0) chk("result", {out_flags, out_result}, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(ref_model(cur));
        end
    end

    task automatic send(input op_t op);
        int n;
        cur      = op;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_wait", 36'(n >= 50), 36'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cur = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 36'(out_valid), 36'd0);
        chk("rst_res", 36'(out_result), 36'd0);
        chk("rst_flg", 36'(out_flags), 36'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rdy_after_rst", 36'(in_ready), 36'd1);

        // Latency: presented now, accepted at the next edge, visible after the one after
        cur = mk(0, 127, 27'h2000000, 2'b00, 0, 3'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_edge1", 36'(out_valid), 36'd0);
        @(posedge clk); #1;
        chk("lat_edge2", 36'(out_valid), 36'd1);
        @(posedge clk); #1;

        // Directed cases
        send(mk(0, 127, 27'h4000000, 2'b00, 0, 3'd0));
        send(mk(0, 130, 27'h0800000, 2'b00, 0, 3'd0));
        send(mk(0, 127, 27'h2000002, 2'b00, 0, 3'd0));
        send(mk(0, 127, 27'h2000006, 2'b00, 0, 3'd0));
        send(mk(1, 127, 27'h2000002, 2'b00, 0, 3'd2));
        send(mk(0, 127, 27'h2000002, 2'b00, 0, 3'd1));
        send(mk(0, 254, 27'h4000000, 2'b00, 0, 3'd0));
        send(mk(0, 254, 27'h4000000, 2'b00, 0, 3'd1));
        send(mk(1, 254, 27'h4000000, 2'b00, 0, 3'd2));
        send(mk(1, 254, 27'h4000000, 2'b00, 0, 3'd3));
        send(mk(0, 1, 27'h1000000, 2'b00, 0, 3'd0));
        send(mk(0, 0, 27'h3FFFFFF, 2'b00, 0, 3'd3));
        send(mk(0, 127, 27'h3FFFFFE, 2'b00, 0, 3'd4));
        send(mk(1, 5, 27'h0000000, 2'b00, 0, 3'd0));
        send(mk(1, 5, 27'h2000000, 2'b10, 0, 3'd0));
        send(mk(0, 5, 27'h2000000, 2'b11, 1, 3'd0));
        send(mk(0, -200, 27'h0000001, 2'b00, 0, 3'd0));
        send(mk(0, 511, 27'h7FFFFFF, 2'b00, 0, 3'd7));
        repeat (4) @(posedge clk);
        #1;
        chk("dir_drain", 36'(exp_q.size()), 36'd0);

        // Backpressure: two ops fill the pipe, the third must wait
        out_ready = 1'b0;
        send(rand_op());
        send(rand_op());
        cur = rand_op();
        in_valid = 1'b1;
        chk("bp_full", 36'(in_ready), 36'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("bp_still_full", 36'(in_ready), 36'd0);
        chk("bp_vld", 36'(out_valid), 36'd1);
        out_ready = 1'b1;
        send(cur);
        send(rand_op());
        repeat (5) @(posedge clk);
        #1;
        chk("bp_drain", 36'(exp_q.size()), 36'd0);

        // Reset with two ops in flight
        out_ready = 1'b0;
        send(rand_op());
        send(rand_op());
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_vld", 36'(out_valid), 36'd0);
        chk("mid_rst_res", 36'(out_result), 36'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("mid_rst_quiet", 36'(out_valid), 36'd0);
        end

        // Random traffic with random stalls on both sides
        repeat (3000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                if ($urandom_range(0, 9) < 7) begin
                    cur = rand_op();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("final_drain", 36'(exp_q.size()), 36'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
